sram_like_arbiter: RTL
======================

# sram_like_arbiter

Two-requester arbiter that shares one SRAM-like bus master port between the CPU's instruction-fetch and data-access ports, so a single `cpu_axi_interface` or memory can serve both. It sits between `mips` and the bridge, uses the same req/addr_ok/data_ok protocol on all three ports, and adds zero cycles of latency. It does three things: arbitrates address phases, holds a grant stable until it is accepted, and returns data_ok in request order through an order FIFO.

## Interface
- `DEPTH`, default 4: maximum outstanding accepted-but-unanswered requests (order-FIFO depth). Must be at least 1.
- `STARVE_MAX`, default 4: number of consecutive data wins over a waiting inst request before inst is forced to win.

Ports:
- `clk`  in  1  clock.
- `resetn`  in  1  synchronous, active-low reset.
- `inst_req`, `inst_wr`  in  1  instruction-port request and write flag.
- `inst_size`  in  2  access size: 0 = byte, 1 = half, 2 = word.
- `inst_addr`, `inst_wdata`  in  32  instruction-port address and write data.
- `inst_rdata`  out  32  read data returned to the instruction port.
- `inst_addr_ok`, `inst_data_ok`  out  1  instruction-port address and data handshakes.
- `data_req`, `data_wr`, `data_size`, `data_addr`, `data_wdata`, `data_rdata`, `data_addr_ok`, `data_data_ok`: data port, same widths and directions as the instruction port.
- `mem_req`, `mem_wr`  out  1  shared-port request and write flag.
- `mem_size`  out  2  shared-port access size.
- `mem_addr`, `mem_wdata`  out  32  shared-port address and write data.
- `mem_rdata`  in  32  read data from the slave.
- `mem_addr_ok`, `mem_data_ok`  in  1  slave address and data handshakes.

## Operation
- **Request:** `mem_req = (inst_req | data_req) & ~full & resetn`. The `mem_wr/size/addr/wdata` fields are muxed from the granted source.
- **Accept:** an accept is `mem_req & mem_addr_ok`. `inst_addr_ok = accept & grant==INST`; `data_addr_ok = accept & grant==DATA`.
- **Grant when unlocked:**
  - DATA wins by default.
  - INST wins if only inst requests.
  - INST also wins if `starve_cnt == STARVE_MAX` and inst_req is asserted.
- **Lock:** when `mem_req & ~mem_addr_ok`, set `lock_v = 1` and `lock_src = grant`.
  - While `lock_v` is set, grant = `lock_src` regardless of priority, so the fields stay stable.
  - The lock clears on accept.
  - Requesters hold req and fields until their addr_ok.
- **Starvation counter:**
  - `starve_cnt` increments (saturating at STARVE_MAX) on each DATA accept while inst_req is asserted.
  - It clears to 0 on each INST accept.
- **Order FIFO:** 1-bit source IDs, DEPTH entries, wrapping read/write pointers and a count.
  - Each accept pushes grant, except in the bypass case below.
  - `full` = count==DEPTH. `mem_req` is gated by `full` even when a pop occurs in the same cycle.
- **Response:**
  - On `mem_data_ok` with count>0: pop the head, and drive `inst_data_ok` or `data_data_ok` according to the head's source ID.
  - Accept and pop in the same cycle leaves count unchanged, with both pointers advancing.
- **Bypass (zero-latency slave):** count==0 with accept and `mem_data_ok` in the same cycle → data_ok goes to the current grant, there is no push, and the FIFO is unchanged.
- **Protocol violation:** `mem_data_ok` with count==0 and no accept is ignored. No data_ok is produced and the state is unchanged.
- **Read data:** `inst_rdata = data_rdata = mem_rdata`, broadcast to both ports; only the port receiving data_ok consumes it.
- **Reset:** resetn low at a clock edge clears the pointers, count, `lock_v` and `starve_cnt`.
  - Outputs during reset: `mem_req`, all addr_ok and all data_ok = 0.
  - Reset mid-transaction discards outstanding IDs; any later `mem_data_ok` is treated as a violation.

## Timing
- Zero added latency. These paths are combinational:
  - req → `mem_req`
  - `mem_addr_ok` → `*_addr_ok`
  - `mem_data_ok` → `*_data_ok`
  - `mem_rdata` → `*_rdata`
- State updates on the rising edge of clk.
- One accept per cycle at most; one response per cycle at most.
- Throughput is one request per cycle when the slave accepts every cycle and the FIFO is not full.
- The grant changes only on cycles where `lock_v` is 0. The lock takes effect from the cycle after the unaccepted request.

## Test plan
- **Both ports, always-ready slave:** inst_req and data_req both held for 5 cycles with an always-ready slave whose data_ok arrives 1 cycle later, and inst_req stays asserted afterwards → DATA is accepted for cycles 1–4. On cycle 5 `starve_cnt` = 4 and INST is accepted. data_ok is returned to the sources in order D,D,D,D,I.
- **Lock under contention:** data_req arrives first, held with `mem_addr_ok` = 0 for 3 cycles. inst_req arrives in cycle 2 at priority level "forced" → `mem_addr` stays at data_addr until the accept, and `data_addr_ok` pulses once.
- **FIFO full:** DEPTH=4, 4 inst accepts with no data_ok → `mem_req` = 0 in cycle 5. A `mem_data_ok` in cycle 5 pops and sets count = 3, and `mem_req` reasserts in cycle 6.
- **Bypass:** with count=0 and `mem_addr_ok` = `mem_data_ok` = `mem_req` (an SRAM-style slave), drive inst fetches at 0xBFC00000 and 0xBFC00004 with `mem_rdata` 0x3C080001 / 0x25080002 → `inst_data_ok` is asserted in the same cycle as `inst_addr_ok`, and `inst_rdata` matches `mem_rdata`.
- **Violation and reset:**
  - A spurious `mem_data_ok` with an empty FIFO → no data_ok is produced.
  - Reset asserted with 2 requests outstanding → count = 0, and a `mem_data_ok` arriving after reset is ignored.

Source files
------------

// File: rtl/sram_like_arbiter_if.sv
// rtl/sram_like_arbiter_if.sv - SRAM-like req/addr_ok/data_ok port bundle
interface sram_like_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        addr_ok;
  logic        data_ok;

  // master issues requests; slave answers with handshakes and read data
  modport master (output req, wr, size, addr, wdata, input rdata, addr_ok, data_ok);
  modport slave  (input req, wr, size, addr, wdata, output rdata, addr_ok, data_ok);
endinterface

// File: rtl/sram_like_arbiter.sv
// rtl/sram_like_arbiter.sv - zero-latency inst/data arbiter onto one SRAM-like port
module sram_like_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                resetn,
  sram_like_arbiter_if.slave  inst,
  sram_like_arbiter_if.slave  data,
  sram_like_arbiter_if.master mem
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ST_W  = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  logic             ids [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             lock_v, lock_src;
  logic [ST_W-1:0]  starve_cnt;

  logic grant_inst, full, empty, starved;
  logic accept, pop, bypass, push, resp_v, resp_inst;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    full    = (count == CNT_W'(DEPTH));
    empty   = (count == '0);
    starved = (starve_cnt == ST_W'(STARVE_MAX));

    // a pending unaccepted request keeps its source so the bus fields stay stable
    if (lock_v) grant_inst = lock_src;
    else        grant_inst = inst.req & (~data.req | starved);

    mem.req   = (inst.req | data.req) & ~full & resetn;
    mem.wr    = grant_inst ? inst.wr    : data.wr;
    mem.size  = grant_inst ? inst.size  : data.size;
    mem.addr  = grant_inst ? inst.addr  : data.addr;
    mem.wdata = grant_inst ? inst.wdata : data.wdata;

    accept = mem.req & mem.addr_ok;
    bypass = empty & accept & mem.data_ok;
    pop    = resetn & ~empty & mem.data_ok;
    push   = accept & ~bypass;

    resp_v    = pop | bypass;
    resp_inst = pop ? ids[rd_ptr] : grant_inst;

    inst.addr_ok = accept & grant_inst;
    data.addr_ok = accept & ~grant_inst;
    inst.data_ok = resp_v & resp_inst;
    data.data_ok = resp_v & ~resp_inst;
    inst.rdata   = mem.rdata;
    data.rdata   = mem.rdata;
  end

  always_ff @(posedge clk) begin
    if (push) ids[wr_ptr] <= grant_inst;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      lock_v     <= 1'b0;
      lock_src   <= 1'b0;
      starve_cnt <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);

      if (accept) begin
        lock_v <= 1'b0;
      end else if (mem.req) begin
        lock_v   <= 1'b1;
        lock_src <= grant_inst;
      end

      if (accept && grant_inst)                 starve_cnt <= '0;
      else if (accept && inst.req && !starved)  starve_cnt <= starve_cnt + ST_W'(1);
    end
  end
endmodule
